// File: rtl/reorder_issue_scheduler.sv
// rtl/reorder_issue_scheduler.sv - tagged round-robin issue stage with credit limit for the reorder buffer
module reorder_issue_scheduler #(
    parameter int DATA_WIDTH   = 64,
    parameter int N_LANES      = 4,
    parameter int DEPTH        = 64,
    parameter int SERIAL_WIDTH = $clog2(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_keep,
    input  logic                              in_last,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_LANES-1:0]                lane_en,
    output logic [N_LANES*DATA_WIDTH-1:0]     lane_data,
    output logic [N_LANES-1:0]                lane_keep,
    output logic [N_LANES-1:0]                lane_last,
    output logic [N_LANES*SERIAL_WIDTH-1:0]   lane_tag,
    output logic [N_LANES-1:0]                lane_valid,
    input  logic [N_LANES-1:0]                lane_ready,
    input  logic                              retire,
    output logic [SERIAL_WIDTH:0]             inflight,
    output logic                              idle,
    output logic                              err_underflow
);
    localparam int PTR_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [SERIAL_WIDTH:0] FULL_COUNT = (SERIAL_WIDTH+1)'(DEPTH);

    logic [PTR_W-1:0]        rr_ptr;
    logic [SERIAL_WIDTH-1:0] serial;
    logic [N_LANES-1:0]      lane_free;
    logic [PTR_W-1:0]        sel;
    logic                    sel_found;
    logic                    issue;

    // A lane can take a beat if enabled and either empty or draining this cycle
    assign lane_free = lane_en & (~lane_valid | lane_ready);

    // Pick the first free lane starting at rr_ptr and wrapping around
    always_comb begin
        int idx;
        logic [PTR_W-1:0] cand;
        sel       = '0;
        sel_found = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int i = 0; i < N_LANES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_LANES) begin
                idx = idx - N_LANES;
            end
            cand = PTR_W'(idx);
            if (!sel_found && lane_free[cand]) begin
                sel       = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Full credit count blocks input even when lanes are free; retire only helps next cycle
    assign in_ready = sel_found && (inflight < FULL_COUNT);
    assign issue    = in_valid && in_ready;
    assign idle     = (inflight == '0) && (lane_valid == '0);

    // Round-robin pointer, serial tag counter and per-lane valid flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            serial     <= '0;
            lane_valid <= '0;
        end else begin
            for (int k = 0; k < N_LANES; k++) begin
                if (issue && (sel == PTR_W'(k))) begin
                    lane_valid[k] <= 1'b1;
                end else if (lane_ready[k]) begin
                    lane_valid[k] <= 1'b0;
                end
            end
            if (issue) begin
                serial <= serial + SERIAL_WIDTH'(1);
                rr_ptr <= (sel == PTR_W'(N_LANES - 1)) ? '0 : sel + PTR_W'(1);
            end
        end
    end

    // Lane payload registers load on issue and otherwise hold their contents
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_LANES; k++) begin
            if (issue && (sel == PTR_W'(k))) begin
                lane_data[k*DATA_WIDTH +: DATA_WIDTH]     <= in_data;
                lane_keep[k]                              <= in_keep;
                lane_last[k]                              <= in_last;
                lane_tag[k*SERIAL_WIDTH +: SERIAL_WIDTH]  <= serial;
            end
        end
    end

    // Credit counter with sticky underflow flag; a retire at zero is ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight      <= '0;
            err_underflow <= 1'b0;
        end else begin
            case ({issue, retire})
                2'b10: inflight <= inflight + (SERIAL_WIDTH+1)'(1);
                2'b01: begin
                    if (inflight == '0) begin
                        err_underflow <= 1'b1;
                    end else begin
                        inflight <= inflight - (SERIAL_WIDTH+1)'(1);
                    end
                end
                2'b11: begin
                    if (inflight == '0) begin
                        inflight <= (SERIAL_WIDTH+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reorder_issue_scheduler.sv
// tb/tb_reorder_issue_scheduler.sv - self-checking bench for reorder_issue_scheduler
module tb_reorder_issue_scheduler;
    localparam int DW = 64;
    localparam int NL = 4;
    localparam int DP = 64;
    localparam int SW = 6;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   in_data;
    logic            in_keep;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [NL-1:0]   lane_en;
    logic [NL*DW-1:0] lane_data;
    logic [NL-1:0]   lane_keep;
    logic [NL-1:0]   lane_last;
    logic [NL*SW-1:0] lane_tag;
    logic [NL-1:0]   lane_valid;
    logic [NL-1:0]   lane_ready;
    logic            retire;
    logic [SW:0]     inflight;
    logic            idle;
    logic            err_underflow;

    int n_checks = 0;
    int n_errors = 0;

    reorder_issue_scheduler #(
        .DATA_WIDTH(DW), .N_LANES(NL), .DEPTH(DP), .SERIAL_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .lane_en(lane_en), .lane_data(lane_data), .lane_keep(lane_keep),
        .lane_last(lane_last), .lane_tag(lane_tag), .lane_valid(lane_valid),
        .lane_ready(lane_ready), .retire(retire), .inflight(inflight),
        .idle(idle), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vin;
        logic [3:0] rdy;
        logic [3:0] en;
        logic       ret;
        logic       exp_ready;
        logic [3:0] exp_valid;
        int         exp_inflight;
        int         exp_lane;
        int         exp_tag;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        retire   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [SW-1:0] tag_of(input int k);
        return lane_tag[k*SW +: SW];
    endfunction

    // Reference model: lane occupancy, credits and tag counter tracked as plain integers
    bit          m_full[NL];
    int          m_tag[NL];
    logic [DW-1:0] m_data[NL];
    bit          m_keep[NL];
    bit          m_last[NL];
    int          m_inflight;
    int          m_serial;
    int          m_rr;
    bit          m_err;

    task automatic model_reset();
        for (int k = 0; k < NL; k++) m_full[k] = 0;
        m_inflight = 0;
        m_serial   = 0;
        m_rr       = 0;
        m_err      = 0;
    endtask

    initial begin
        int acc;
        int order[8];
        logic [3:0] vbits;

        rst_n = 1'b0; in_data = '0; in_keep = 0; in_last = 0; in_valid = 0;
        lane_en = 4'hF; lane_ready = 4'hF; retire = 0;

        //             vin rdy    en     ret rdyx valid  infl lane tag
        vecs[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0001, 1,  0, 0};
        vecs[1]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0010, 2,  1, 1};
        vecs[2]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0100, 3,  2, 2};
        vecs[3]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b1000, 4,  3, 3};
        vecs[4]  = '{1'b1, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0001, 5,  0, 4};
        vecs[5]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 4'b0010, 5,  1, 5};
        vecs[6]  = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 4'b0000, 5, -1, 0};
        vecs[7]  = '{1'b1, 4'hF, 4'h0, 1'b0, 1'b0, 4'b0000, 5, -1, 0};
        vecs[8]  = '{1'b1, 4'hF, 4'h5, 1'b0, 1'b1, 4'b0100, 6,  2, 6};
        vecs[9]  = '{1'b1, 4'hF, 4'h5, 1'b0, 1'b1, 4'b0001, 7,  0, 7};
        vecs[10] = '{1'b1, 4'hF, 4'h5, 1'b0, 1'b1, 4'b0100, 8,  2, 8};
        vecs[11] = '{1'b0, 4'hF, 4'h5, 1'b1, 1'b1, 4'b0000, 7, -1, 0};

        // Reset state
        do_reset();
        chk("reset_lane_valid", lane_valid, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_idle", idle, 1);
        chk("reset_err", err_underflow, 0);

        // Table-driven vectors from reset
        for (int i = 0; i < 12; i++) begin
            in_valid = vecs[i].vin; lane_ready = vecs[i].rdy; lane_en = vecs[i].en;
            retire = vecs[i].ret; in_data = {$urandom, $urandom};
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
            tick();
            chk($sformatf("vec%0d_lane_valid", i), lane_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_inflight", i), inflight, vecs[i].exp_inflight);
            if (vecs[i].exp_lane >= 0)
                chk($sformatf("vec%0d_tag", i), tag_of(vecs[i].exp_lane), vecs[i].exp_tag);
        end
        in_valid = 0; retire = 0;

        // Fill to DEPTH, then a retire releases one credit a cycle later and the tag wraps
        do_reset();
        lane_en = 4'hF; lane_ready = 4'hF; in_valid = 1; acc = 0;
        for (int c = 0; c < 80; c++) begin
            #1;
            if (in_ready) begin
                tick();
                chk("fill_tag", tag_of(acc % NL), acc % DP);
                acc++;
            end else begin
                tick();
            end
        end
        chk("fill_count", acc, 64);
        chk("fill_inflight", inflight, 64);
        #1;
        chk("fill_in_ready", in_ready, 0);
        retire = 1;
        #1;
        chk("full_retire_same_cycle_ready", in_ready, 0);
        tick();
        retire = 0;
        #1;
        chk("after_retire_inflight", inflight, 63);
        chk("after_retire_ready", in_ready, 1);
        tick();
        chk("wrap_valid", lane_valid[0], 1);
        chk("wrap_tag", tag_of(0), 0);
        chk("wrap_inflight", inflight, 64);
        in_valid = 0;

        // Lane 1 stalls: later beats skip it, tags stay contiguous
        do_reset();
        order = '{0, 1, 2, 3, 0, 2, 3, 0};
        lane_ready = 4'b1101; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("stall_in_ready", in_ready, 1);
            tick();
            chk($sformatf("stall_beat%0d_valid", i), lane_valid[order[i]], 1);
            chk($sformatf("stall_beat%0d_tag", i), tag_of(order[i]), i);
            if (i >= 1) begin
                chk("stall_lane1_hold_valid", lane_valid[1], 1);
                chk("stall_lane1_hold_tag", tag_of(1), 1);
            end
        end
        in_valid = 0; lane_ready = 4'hF;
        tick();
        chk("stall_drained", lane_valid, 0);
        chk("stall_inflight", inflight, 8);
        chk("stall_not_idle", idle, 0);

        // Underflow is sticky; issue with retire at zero credits yields one in flight
        do_reset();
        retire = 1; in_valid = 0;
        tick();
        chk("uflow_err", err_underflow, 1);
        chk("uflow_inflight", inflight, 0);
        retire = 0;
        tick(); tick();
        chk("uflow_sticky", err_underflow, 1);
        retire = 1; in_valid = 1; lane_en = 4'hF; lane_ready = 4'hF;
        tick();
        chk("issue_retire_zero_inflight", inflight, 1);
        retire = 0; in_valid = 0;
        do_reset();
        chk("uflow_cleared_by_reset", err_underflow, 0);

        // Reset while three lanes hold beats
        lane_ready = 4'h0; in_valid = 1;
        tick(); tick(); tick();
        chk("prereset_valid", lane_valid, 4'b0111);
        chk("prereset_inflight", inflight, 3);
        chk("prereset_idle", idle, 0);
        rst_n = 0; in_valid = 0;
        tick();
        rst_n = 1;
        chk("midreset_valid", lane_valid, 0);
        chk("midreset_inflight", inflight, 0);
        chk("midreset_idle", idle, 1);
        in_valid = 1; lane_ready = 4'hF;
        tick();
        chk("postreset_lane0", lane_valid, 4'b0001);
        chk("postreset_tag", tag_of(0), 0);
        in_valid = 0;

        // Randomized run against the reference model
        do_reset();
        model_reset();
        lane_en = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            int  sel;
            bit  exp_ready;
            bit  iss;
            int  old;
            if (c % 50 == 0) lane_en = 4'($urandom_range(0, 15));
            if (c % 50 == 1 && lane_en == 0) lane_en = 4'hF;
            in_valid   = ($urandom_range(0, 9) < 7);
            lane_ready = 4'($urandom);
            retire     = (m_inflight > 0) && ($urandom_range(0, 2) == 0);
            in_data    = {$urandom, $urandom};
            in_keep    = 1'($urandom);
            in_last    = 1'($urandom);
            sel = -1;
            for (int j = 0; j < NL; j++) begin
                int k;
                k = (m_rr + j) % NL;
                if (sel < 0 && lane_en[k] && (!m_full[k] || lane_ready[k])) sel = k;
            end
            exp_ready = (sel >= 0) && (m_inflight < DP);
            iss = in_valid && exp_ready;
            #1;
            chk("rand_in_ready", in_ready, exp_ready);
            for (int k = 0; k < NL; k++)
                if (m_full[k] && lane_ready[k]) m_full[k] = 0;
            if (iss) begin
                m_full[sel] = 1; m_tag[sel] = m_serial; m_data[sel] = in_data;
                m_keep[sel] = in_keep; m_last[sel] = in_last;
                m_serial = (m_serial + 1) % DP;
                m_rr = (sel + 1) % NL;
            end
            old = m_inflight;
            if (retire && old == 0 && !iss) m_err = 1;
            m_inflight = old + (iss ? 1 : 0) - ((retire && old > 0) ? 1 : 0);
            tick();
            vbits = '0;
            for (int k = 0; k < NL; k++) vbits[k] = m_full[k];
            chk("rand_lane_valid", lane_valid, vbits);
            chk("rand_inflight", inflight, m_inflight);
            chk("rand_idle", idle, (m_inflight == 0) && (vbits == 0));
            chk("rand_err", err_underflow, m_err);
            for (int k = 0; k < NL; k++) begin
                if (m_full[k]) begin
                    chk("rand_tag", tag_of(k), m_tag[k]);
                    chk("rand_data", lane_data[k*DW +: DW], m_data[k]);
                    chk("rand_keep", lane_keep[k], m_keep[k]);
                    chk("rand_last", lane_last[k], m_last[k]);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reorder_issue_scheduler.md
Name: reorder_issue_scheduler

Overview:
- Issue-side controller for the reorder buffer.
- Stamps each beat of an in-order input stream with a wrapping serial tag and distributes beats round-robin across N_LANES out-of-order processing lanes.
- Limits beats in flight to DEPTH with a credit counter; one credit returns per beat retired at the reorder buffer output.
- Guarantees the reorder buffer never receives a tag whose slot is still occupied.

Parameters:
- DATA_WIDTH, 64, width of the data payload.
- N_LANES, 4, number of downstream lanes (1..16).
- DEPTH, 64, reorder buffer slots; power of two, at least 2.
- SERIAL_WIDTH, $clog2(DEPTH), tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  DATA_WIDTH  input payload
- in_keep  in  1  input keep flag
- in_last  in  1  input last flag
- in_valid  in  1  input valid
- in_ready  out  1  input ready
- lane_en  in  N_LANES  per-lane enable mask; quasi-static
- lane_data  out  N_LANES*DATA_WIDTH  per-lane payload
- lane_keep  out  N_LANES  per-lane keep
- lane_last  out  N_LANES  per-lane last
- lane_tag  out  N_LANES*SERIAL_WIDTH  per-lane serial tag
- lane_valid  out  N_LANES  per-lane valid
- lane_ready  in  N_LANES  per-lane ready
- retire  in  1  one pulse per beat accepted at the reorder buffer output
- inflight  out  SERIAL_WIDTH+1  beats issued and not yet retired
- idle  out  1  inflight==0 and no lane_valid asserted
- err_underflow  out  1  sticky; set by retire while inflight==0

Behaviour:
- Reset (rst_n low at a clk edge), effective the next cycle:
  - lane_valid=0, inflight=0, serial=0, rr_ptr=0, err_underflow=0, idle=1.
  - Lane data, keep, last and tag registers are not reset.
  - Reset mid-operation drops all beats held in lane registers and discards credits. The environment must reset the reorder buffer in the same cycle.
- Lane free: lane k is free when lane_en[k] && (!lane_valid[k] || lane_ready[k]).
- Selection:
  - Pick the first free lane scanning rr_ptr, rr_ptr+1, ... mod N_LANES.
  - Selection is combinational from registered state, lane_en and lane_ready.
- in_ready is asserted when some lane is free and inflight < DEPTH.
  - Combinational; does not depend on in_valid.
- Issue occurs when in_valid && in_ready. At the next edge:
  - The selected lane register loads {in_data, in_keep, in_last, serial}, and its lane_valid is set.
  - serial increments, wrapping mod 2^SERIAL_WIDTH (DEPTH-1 goes to 0).
  - rr_ptr becomes (selected+1) mod N_LANES.
- Latency: a beat accepted in cycle t appears on lane_valid in cycle t+1.
- Lane handshakes:
  - A lane register holds its contents while lane_valid && !lane_ready.
  - A lane register clears lane_valid on lane_valid && lane_ready when no new issue targets that lane.
  - Drain and reload of the same lane in one cycle gives back-to-back beats at full rate.
- Credits, updated every cycle:
  - issue only: inflight+1.
  - retire only: inflight-1.
  - issue and retire together: inflight unchanged.
  - retire with inflight==0 and no issue: inflight stays 0 and err_underflow sets.
  - retire with inflight==0 and an issue in the same cycle: inflight becomes 1; no error.
  - Full (inflight==DEPTH): in_ready=0 even if lanes are free. A retire in that cycle does not raise in_ready until the next cycle.
- Disabled lanes:
  - A lane with lane_en[k]=0 is never selected.
  - A beat already held in a lane when its enable drops still drains normally.
  - All lanes disabled: in_ready=0.
- Tag ordering: tags issue strictly in input order with no gaps, independent of lane choice.
- idle is registered-state based: (inflight==0) && (lane_valid==0).

Test Plan:
- Reset, then push 8 beats with all lanes ready, N_LANES=4 -> lanes hit 0,1,2,3,0,1,2,3; tags 0..7; one beat per cycle; inflight=8 with no retire.
- DEPTH=64, no retire, in_valid held high -> exactly 64 beats accepted, then in_ready=0 and inflight=64. One retire pulse -> in_ready=1 the following cycle; the next beat carries tag 0 (wrap).
- lane_ready[1]=0 with all lanes enabled -> lane 1 holds its first beat stable. Subsequent beats skip lane 1 (order 0,2,3,0,...) until lane 1 drains; tags stay contiguous.
- lane_en=4'b0101 -> beats alternate lanes 0 and 2. lane_en=0 -> in_ready=0 and no issue.
- Issue and retire in the same cycle at inflight=5 -> inflight stays 5. Retire at inflight=0 with no issue -> err_underflow=1 and sticks until reset; inflight stays 0.
- Assert rst_n=0 for 1 cycle while 3 lanes hold beats -> next cycle lane_valid=0, inflight=0, idle=1; the first beat after reset carries tag 0 and goes to lane 0.
